ac_store_buffer: RTL and testbench

//  Write-side companion to the accumulator: queues AC store requests (address + AC data)
//  and drains them to data memory over a req/ack write handshake.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/sb_fifo.sv | 64 ++++++
 rtl/ac_store_buffer.sv | 89 ++++++++
 tb/tb_ac_store_buffer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and store-buffer FSM encoding
package cpu_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        REQ  = ST_REQ,
        GAP  = ST_GAP
    } sb_state_t;

endpackage

// File: rtl/sb_fifo.sv
// rtl/sb_fifo.sv - store queue storage, read/write pointers and occupancy
module sb_fifo
    import cpu_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [AW+DW-1:0] entries [DEPTH];
    logic [PW-1:0]    rp;
    logic [PW-1:0]    wp;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign {head_addr, head_data} = entries[rp];

    // Payload storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wp] <= {push_addr, push_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ac_store_buffer.sv
// rtl/ac_store_buffer.sv - queues AC stores and drains them over a req/ack write port
module ac_store_buffer
    import cpu_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st_valid,
    input  logic [AW-1:0]              st_addr,
    input  logic [DW-1:0]              st_data,
    output logic                       st_ready,
    output logic                       mem_req,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_wdata,
    input  logic                       mem_ack,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf
);

    sb_state_t     state;
    logic          full;
    logic          pop;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;

    // The in-flight entry stays in the queue until the memory acknowledges it.
    assign pop      = (state == REQ) && mem_ack;
    assign st_ready = !full;

    sb_fifo #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (st_valid),
        .push_addr (st_addr),
        .push_data (st_data),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ovf       <= 1'b0;
        end else begin
            if (st_valid && full) begin
                ovf <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state     <= REQ;
                        mem_req   <= 1'b1;
                        mem_addr  <= head_addr;
                        mem_wdata <= head_data;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state   <= GAP;
                        mem_req <= 1'b0;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ac_store_buffer.sv
// tb/tb_ac_store_buffer.sv - scoreboard bench for ac_store_buffer
module tb_ac_store_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       st_valid = 1'b0;
    logic [7:0] st_addr = '0;
    logic [7:0] st_data = '0;
    logic       st_ready;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_ack;
    logic       empty;
    logic [2:0] count;
    logic       ovf;

    logic auto_ack   = 1'b0;
    logic manual_ack = 1'b0;
    logic ack_en     = 1'b0;
    logic chk_len    = 1'b1;
    int   ack_lat    = 1;
    int   reqcyc     = 0;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] exp_q [$];

    assign mem_ack = auto_ack | manual_ack;

    always #5 clk = ~clk;

    ac_store_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_ready  (st_ready),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .empty     (empty),
        .count     (count),
        .ovf       (ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: acks on the ack_lat-th request cycle, decided 2 time units after the edge.
    always @(posedge clk) begin
        #2;
        if (ack_en && rst && mem_req && !auto_ack) begin
            reqcyc++;
            if (reqcyc >= ack_lat) begin
                auto_ack = 1'b1;
                reqcyc   = 0;
            end
        end else begin
            auto_ack = 1'b0;
            reqcyc   = 0;
        end
    end

    // Monitor: checks each issued write against the scoreboard and the handshake shape.
    logic       prev_req = 1'b0;
    int         gap_cnt  = 0;
    int         req_len  = 0;
    logic [7:0] cur_addr = '0;
    logic [7:0] cur_data = '0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_req = 1'b0;
            gap_cnt  = 0;
            req_len  = 0;
        end else begin
            if (gap_cnt > 0) begin
                chk("gap_low", 32'(mem_req), 32'd0);
                gap_cnt--;
            end else if (mem_req) begin
                if (!prev_req) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_write: got %h/%h, expected no write", mem_addr, mem_wdata);
                    end else begin
                        logic [15:0] e;
                        e = exp_q.pop_front();
                        chk("write_addr", 32'(mem_addr), 32'(e[15:8]));
                        chk("write_data", 32'(mem_wdata), 32'(e[7:0]));
                    end
                    req_len  = 1;
                    cur_addr = mem_addr;
                    cur_data = mem_wdata;
                end else begin
                    chk("addr_stable", 32'(mem_addr), 32'(cur_addr));
                    chk("data_stable", 32'(mem_wdata), 32'(cur_data));
                    req_len++;
                end
                if (mem_ack) begin
                    if (chk_len) chk("req_len", 32'(req_len), 32'(ack_lat));
                    gap_cnt = 2;
                end
            end
            prev_req = mem_req;
        end
    end

    // Called at posedge+1; waits for room, then presents one store for one edge.
    task automatic store(input logic [7:0] a, input logic [7:0] d);
        for (int t = 0; t < 100 && !st_ready; t++) begin
            @(posedge clk); #1;
        end
        chk("store_ready", 32'(st_ready), 32'd1);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        @(posedge clk); #1;
        st_valid = 1'b0;
        exp_q.push_back({a, d});
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && !(empty && !mem_req); t++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_count", 32'(count), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        for (int t = 0; t < 50 && !mem_req; t++) begin
            @(posedge clk); #1;
        end
        chk("req_seen", 32'(mem_req), 32'd1);
    endtask

    initial begin
        #2;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // single store, ack on first request cycle
        ack_en = 1'b1; ack_lat = 1; chk_len = 1'b1;
        store(8'h10, 8'hA5);
        chk("t1_count", 32'(count), 32'd1);
        drain();

        // fill with acks held off, then overflow attempt
        ack_en = 1'b0; chk_len = 1'b0;
        for (int i = 1; i <= 4; i++) store(8'(i), 8'(8'hC0 + i));
        chk("t2_count_full", 32'(count), 32'd4);
        chk("t2_ready_low", 32'(st_ready), 32'd0);
        chk("t2_ovf_before", 32'(ovf), 32'd0);
        st_valid = 1'b1; st_addr = 8'h05; st_data = 8'hC5;
        @(posedge clk); #1;
        st_valid = 1'b0;
        chk("t2_ovf_set", 32'(ovf), 32'd1);
        chk("t2_count_kept", 32'(count), 32'd4);
        ack_en = 1'b1; ack_lat = 1;
        drain();
        chk("t2_ovf_sticky", 32'(ovf), 32'd1);

        // slow memory
        chk_len = 1'b1; ack_lat = 3;
        store(8'h40, 8'h3C);
        store(8'h41, 8'h96);
        store(8'h42, 8'h0F);
        drain();

        // push on the ack edge with two entries held
        ack_en = 1'b0; chk_len = 1'b0;
        store(8'h50, 8'h11);
        store(8'h51, 8'h22);
        wait_req();
        chk("t4_count_pre", 32'(count), 32'd2);
        st_valid = 1'b1; st_addr = 8'h52; st_data = 8'h33;
        manual_ack = 1'b1;
        @(posedge clk); #1;
        st_valid = 1'b0;
        manual_ack = 1'b0;
        exp_q.push_back({8'h52, 8'h33});
        chk("t4_count_same", 32'(count), 32'd2);
        chk("t4_req_dropped", 32'(mem_req), 32'd0);
        ack_en = 1'b1; ack_lat = 1;
        drain();

        // wrap with steady acks
        chk_len = 1'b1; ack_lat = 1;
        for (int i = 0; i < 6; i++) store(8'(8'h20 + i), 8'(8'h70 + 3 * i));
        drain();

        // reset during a request, then a stale ack
        ack_en = 1'b0;
        store(8'h60, 8'hEE);
        wait_req();
        #2;
        rst = 1'b0;
        #1;
        chk("t6_req_cleared", 32'(mem_req), 32'd0);
        chk("t6_count_cleared", 32'(count), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_ready", 32'(st_ready), 32'd1);
        chk("t6_ovf_cleared", 32'(ovf), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        manual_ack = 1'b1;
        @(posedge clk); #1;
        manual_ack = 1'b0;
        chk("t6_stale_count", 32'(count), 32'd0);
        chk("t6_stale_empty", 32'(empty), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_idle_req", 32'(mem_req), 32'd0);
        chk("t6_idle_count", 32'(count), 32'd0);

        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
